pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/pipe_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
// Contents:
//   state_e          controller FSM state encoding
//   load_use_hazard  detects an ID-stage read of a load result still in EX
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LS_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

    // A load in EX whose destination (other than x0) is a source of the ID instruction.
    function automatic logic load_use_hazard(
        input logic       ex_is_load,
        input logic [4:0] ex_rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return ex_is_load && (ex_rd != 5'd0) && ((ex_rd == rs1) || (ex_rd == rs2));
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline controller: arbitrates jump redirects, data-memory load/store stalls
// and load-use hazard stalls.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   jump_i, jump_addr_i          taken jump pulse and target from EXU
//   ls_start_i, ls_we_i          load/store request pulse and direction
//   mem_ack_i                    data-memory completion
//   id_rs1_i, id_rs2_i           ID-stage source registers
//   ex_rd_i, ex_is_load_i        EX-stage destination register and load flag
//   jump_hold_o                  NOP-inject into IDU
//   ls_hold_o, pc_hold_o         freeze IDU/EXU registers, freeze PC/IFU
//   pc_load_o, pc_target_o       PC redirect and target
//   mem_req_o, mem_we_o          registered data-memory request
//   ls_err_o                     one-cycle pulse on load/store timeout abort
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned LS_TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    input  logic        ls_start_i,
    input  logic        ls_we_i,
    input  logic        mem_ack_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_is_load_i,
    output logic        jump_hold_o,
    output logic        ls_hold_o,
    output logic        pc_hold_o,
    output logic        pc_load_o,
    output logic [31:0] pc_target_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        ls_err_o
);

    // A jump taken from IDLE/FLUSH already spent one hold cycle in the redirect
    // cycle; a deferred jump spends its whole hold inside FLUSH.
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] FLUSH_FULL   = 3'(FLUSH_CYCLES);
    localparam logic [7:0] TMO_LAST     = 8'(LS_TIMEOUT - 1);
    localparam bit         SHORT_FLUSH  = (FLUSH_CYCLES == 1);

    state_e      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic [32:0] pend_q, pend_d;          // {valid, target} of a deferred jump
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        ls_err_q, ls_err_d;
    logic        lu_stall_q, lu_stall_d;  // load-use stall issued last cycle

    logic        jump_hold_s, ls_hold_s, pc_hold_s, pc_load_s;
    logic [31:0] pc_target_s;
    logic        ls_exit_s;
    logic        hazard_s;

    // Next-state and combinational hold/redirect decode.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        pend_d      = pend_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        ls_err_d    = 1'b0;
        lu_stall_d  = 1'b0;
        jump_hold_s = 1'b0;
        ls_hold_s   = 1'b0;
        pc_hold_s   = 1'b0;
        pc_load_s   = 1'b0;
        pc_target_s = 32'd0;
        ls_exit_s   = 1'b0;
        hazard_s    = load_use_hazard(ex_is_load_i, ex_rd_i, id_rs1_i, id_rs2_i);

        case (state_q)
            ST_IDLE: begin
                if (ls_start_i) begin
                    // Load/store goes first; a simultaneous jump is deferred.
                    ls_hold_s = 1'b1;
                    pc_hold_s = 1'b1;
                    mem_req_d = 1'b1;
                    mem_we_d  = ls_we_i;
                    tmo_cnt_d = 8'd0;
                    state_d   = ST_LS_WAIT;
                    if (jump_i) begin
                        pend_d = {1'b1, jump_addr_i};
                    end else begin
                        pend_d = pend_q;
                    end
                end else if (jump_i) begin
                    pc_load_s   = 1'b1;
                    pc_target_s = jump_addr_i;
                    jump_hold_s = 1'b1;
                    flush_cnt_d = FLUSH_RELOAD;
                    state_d     = SHORT_FLUSH ? ST_IDLE : ST_FLUSH;
                end else if (hazard_s && !lu_stall_q) begin
                    // The frozen EX stage keeps the hazard visible; stall only once.
                    ls_hold_s  = 1'b1;
                    pc_hold_s  = 1'b1;
                    lu_stall_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LS_WAIT: begin
                ls_hold_s = 1'b1;
                pc_hold_s = 1'b1;
                tmo_cnt_d = tmo_cnt_q + 8'd1;
                if (jump_i) begin
                    pend_d = {1'b1, jump_addr_i};
                end else begin
                    pend_d = pend_q;
                end
                if (mem_ack_i) begin
                    ls_exit_s = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    ls_exit_s = 1'b1;
                    ls_err_d  = 1'b1;
                end else begin
                    ls_exit_s = 1'b0;
                end
                if (ls_exit_s) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    tmo_cnt_d = 8'd0;
                    if (jump_i || pend_q[32]) begin
                        flush_cnt_d = FLUSH_FULL;
                        state_d     = ST_FLUSH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_LS_WAIT;
                end
            end

            ST_FLUSH: begin
                jump_hold_s = 1'b1;
                if (jump_i) begin
                    // A newer jump supersedes whatever was in flight.
                    pc_load_s   = 1'b1;
                    pc_target_s = jump_addr_i;
                    pend_d      = 33'd0;
                    flush_cnt_d = FLUSH_RELOAD;
                    state_d     = SHORT_FLUSH ? ST_IDLE : ST_FLUSH;
                end else begin
                    if (pend_q[32]) begin
                        pc_load_s   = 1'b1;
                        pc_target_s = pend_q[31:0];
                        pend_d      = 33'd0;
                    end else begin
                        pend_d = pend_q;
                    end
                    if (flush_cnt_q <= 3'd1) begin
                        flush_cnt_d = 3'd0;
                        state_d     = ST_IDLE;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 3'd1;
                        state_d     = ST_FLUSH;
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                flush_cnt_d = 3'd0;
                tmo_cnt_d   = 8'd0;
                pend_d      = 33'd0;
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
            end
        endcase

        // Redirect has priority over any PC freeze.
        if (pc_load_s) begin
            pc_hold_s = 1'b0;
        end else begin
            pc_hold_s = pc_hold_s;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= 3'd0;
            tmo_cnt_q   <= 8'd0;
            pend_q      <= 33'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            ls_err_q    <= 1'b0;
            lu_stall_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            pend_q      <= pend_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            ls_err_q    <= ls_err_d;
            lu_stall_q  <= lu_stall_d;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign jump_hold_o = rst_n & jump_hold_s;
    assign ls_hold_o   = rst_n & ls_hold_s;
    assign pc_hold_o   = rst_n & pc_hold_s;
    assign pc_load_o   = rst_n & pc_load_s;
    assign pc_target_o = rst_n ? pc_target_s : 32'd0;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign ls_err_o    = ls_err_q;

endmodule
